// File: rtl/alu_result_stage.sv
// Registered result stage behind the arithmetic unit: derives result flags, substitutes
// divide-by-zero results, buffers entries in a 2-deep skid buffer and keeps status flags.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opsel,
    input  logic [WIDTH-1:0] in_op_a,
    input  logic [WIDTH-1:0] in_op_b,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cf,
    input  logic             in_ovf,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_flags_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic [4:0]       out_flags,
    output logic [4:0]       status_flags,
    input  logic             status_clr
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RD_W-1:0]  rd;
        logic [4:0]       flags;
        logic             flags_we;
    } entry_t;

    state_t           state;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           new_entry;
    logic             in_ready_q;
    logic [4:0]       status_q;
    logic             accept;
    logic             emit;
    logic             is_div;
    logic             dz;
    logic             invalid_op;
    logic             cv_en;
    logic [WIDTH-1:0] final_result;

    assign accept = in_valid && in_ready_q;
    assign emit   = (state != EMPTY) && out_ready;

    // Flags are formed from the substituted result, so z/n reflect what software sees.
    always_comb begin
        is_div     = (in_opsel == 3'b100) || (in_opsel == 3'b101);
        dz         = is_div && (in_op_b == '0);
        invalid_op = (in_opsel[2:1] == 2'b11);
        cv_en      = (in_opsel[2:1] == 2'b00);

        if (invalid_op)
            final_result = '0;
        else if (dz && (in_opsel == 3'b100))
            final_result = '1;
        else if (dz)
            final_result = in_op_a;
        else
            final_result = in_result;

        new_entry          = '0;
        new_entry.result   = final_result;
        new_entry.rd       = in_rd;
        new_entry.flags    = {dz, cv_en & in_ovf, cv_en & in_cf,
                              final_result[WIDTH-1], (final_result == '0)};
        new_entry.flags_we = in_flags_we;
    end

    // in_ready is tracked as its own register so it never depends on out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            in_ready_q <= 1'b1;
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= new_entry;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        skid_q     <= new_entry;
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (accept) begin
                        main_q <= new_entry;
                    end else if (emit) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Sticky dz: a same-edge clear is applied before the emitted entry can set it again.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
        end else if (emit && main_q.flags_we) begin
            status_q[3:0] <= main_q.flags[3:0];
            status_q[4]   <= (status_q[4] & ~status_clr) | main_q.flags[4];
        end else if (status_clr) begin
            status_q[4] <= 1'b0;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (state != EMPTY);
    assign out_result   = main_q.result;
    assign out_rd       = main_q.rd;
    assign out_flags    = main_q.flags;
    assign status_flags = status_q;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly downstream of the combinational arithmetic unit. It captures the unit's result and carry/overflow outputs with a valid/ready handshake.
- Derives per-operation flags: zero, negative, carry, overflow and divide-by-zero. On divide-by-zero it substitutes architecturally defined results.
- Maintains a status-flag register for the branch/GPIO logic.
- A 2-entry skid buffer gives a fully registered in_ready with no bubbles at full throughput.

Parameters:
WIDTH, 32, datapath width; equals REG_WIDTH.
RD_W, 5, destination register index width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream holds a valid arithmetic result
in_ready  out  1  stage can accept; registered, not combinational from out_ready
in_opsel  in  3  opsel that produced in_result: 00x add/sub, 010 mul low, 011 mul high, 100 div, 101 rem, others invalid
in_op_a  in  WIDTH  operand A fed to the arithmetic unit
in_op_b  in  WIDTH  operand B fed to the arithmetic unit
in_result  in  WIDTH  arithmetic unit result
in_cf  in  1  arithmetic unit carry
in_ovf  in  1  arithmetic unit overflow
in_rd  in  RD_W  destination register tag, passed through
in_flags_we  in  1  this operation updates status_flags
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_result  out  WIDTH  final result
out_rd  out  RD_W  destination tag
out_flags  out  5  {dz, v, c, n, z} of this entry
status_flags  out  5  {dz, v, c, n, z} architectural status
status_clr  in  1  clears sticky dz

Behaviour:
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- Flag computation is done on accept, from inputs:
  - dz = (opsel==100 || opsel==101) && in_op_b==0.
  - Result substitution: dz && opsel==100 gives all ones. dz && opsel==101 gives in_op_a. Otherwise the result is in_result.
  - z = (final result == 0). n = final result[WIDTH-1].
  - c = in_cf and v = in_ovf only when opsel[2:1]==00; otherwise both are 0.
  - Invalid opsel (110/111) gives result 0, flags z=1 and the rest 0.
- Buffer structure: main register (drives outputs) plus skid register. Three states:
  - EMPTY: out_valid=0, in_ready=1. Accept → ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept with no emit → TWO (new entry into skid).
    - Accept with emit → ONE (main reloaded).
    - Emit only → EMPTY.
  - TWO: out_valid=1, in_ready=0. Emit → ONE (skid moves to main). in_valid is ignored.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle when out_ready is held high.
- Order is strictly FIFO. Outputs are stable while out_valid && !out_ready.
- status_flags update happens on emit, only if the emitted entry has flags_we=1:
  - z, n, c, v are overwritten.
  - dz becomes dz_old | entry.dz (sticky).
- status_clr clears dz at the clock edge.
  - Same-cycle clr and flag-writing emit: dz = entry.dz (clear applied first, then set).
  - z, n, c, v are unaffected by clr.
- Reset:
  - State goes to EMPTY; out_valid=0 and in_ready=0 during the reset cycle, in_ready=1 on the first cycle after.
  - out_result=0, out_rd=0, out_flags=0, status_flags=0.
  - Reset mid-operation discards both entries, with no status update.
- All widths are unsigned; no arithmetic is performed beyond the zero compare.

Test Plan:
1. Single add: opsel=000, result=0, cf=1, ovf=0, flags_we=1, out_ready=1. Expect out_valid the next cycle, out_flags=00101, then status_flags=00101.
2. Divide-by-zero: opsel=100, op_b=0. Expect out_result=FFFFFFFF and dz=1. Then opsel=101, op_a=0x1234, op_b=0. Expect out_result=0x1234 and status dz sticky=1. Assert status_clr → dz=0.
3. Backpressure: out_ready=0, push 3 results A,B,C back-to-back. Expect in_ready=0 after B (TWO) and C held off. Release out_ready. Expect emit order A,B,C with no drops or duplicates, and outputs stable while stalled.
4. Full throughput: 16 consecutive mul_low results with in_valid=1 and out_ready=1. Expect 16 emits in 16 consecutive cycles, in_ready constantly 1.
5. flags_we=0 on a sub producing result 0x80000000, with prior status=00000. Expect out_flags n=1 and status_flags unchanged at 00000.
6. Reset in TWO state: hold rst for 1 cycle. Expect out_valid=0, status_flags=0, in_ready=0 during reset then 1, and no emit of the old entries.
